// File: rtl/mux_result_buffer_pkg.sv
// Shared sizing constants and the stored entry record for the mux result buffer.
// Every buffer slot carries the result word, its select tag and the precomputed flags.
package mux_result_pkg;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
        logic             zero;
        logic             neg;
    } entry_t;

endpackage

// File: rtl/mux_result_buffer_if.sv
// Producer/consumer bundle around the mux result buffer.
// The slave side is the buffer; the master side is the upstream stage plus the consumer.
interface mux_result_buffer_if #(
    parameter int WIDTH = mux_result_pkg::WIDTH,
    parameter int DEPTH = mux_result_pkg::DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] DATA_IN;
    logic [1:0]       SEL_IN;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic [1:0]       OUT_SEL;
    logic             OUT_ZERO;
    logic             OUT_NEG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [CNT_W-1:0] COUNT;
    logic [7:0]       DROP_CNT;

    modport master (
        output DATA_IN, SEL_IN, IN_VALID, OUT_READY,
        input  IN_READY, OUT_DATA, OUT_SEL, OUT_ZERO, OUT_NEG, OUT_VALID, COUNT, DROP_CNT
    );

    modport slave (
        input  DATA_IN, SEL_IN, IN_VALID, OUT_READY,
        output IN_READY, OUT_DATA, OUT_SEL, OUT_ZERO, OUT_NEG, OUT_VALID, COUNT, DROP_CNT
    );

endinterface

// File: rtl/mux_result_buffer_result_flags.sv
// Combinational zero/negative flag generation for a result word.
module result_flags #(
    parameter int WIDTH = mux_result_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output logic             zero,
    output logic             neg
);

    assign zero = (data == {WIDTH{1'b0}});
    assign neg  = data[WIDTH-1];

endmodule

// File: rtl/mux_result_buffer.sv
// First-word-fall-through result buffer with stored flags and a saturating stall counter.
// The head entry is pre-selected into registers so every OUT_* comes straight from a flop.
module mux_result_buffer #(
    parameter int WIDTH = mux_result_pkg::WIDTH,
    parameter int DEPTH = mux_result_pkg::DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_result_buffer_if.slave  bus
);

    typedef mux_result_pkg::entry_t entry_t;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       drop_q, drop_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    entry_t           head_q, head_d;

    logic             push_s;
    logic             pop_s;
    logic             zero_s;
    logic             neg_s;
    entry_t           in_entry_s;

    result_flags #(.WIDTH(WIDTH)) u_flags (
        .data (bus.DATA_IN),
        .zero (zero_s),
        .neg  (neg_s)
    );

    // Next-state for pointers, occupancy, stall counter and the pre-selected head.
    always_comb begin
        push_s     = bus.IN_VALID && in_ready_q;
        pop_s      = out_valid_q && bus.OUT_READY;
        in_entry_s = '{data: bus.DATA_IN, sel: bus.SEL_IN, zero: zero_s, neg: neg_s};

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.IN_VALID && !in_ready_q && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end

        in_ready_d  = (count_d < CNT_W'(DEPTH));
        out_valid_d = (count_d != CNT_W'(0));

        // The slot being written this edge becomes the head when it is the next read slot.
        if (count_d == CNT_W'(0)) begin
            head_d = '0;
        end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            head_d = in_entry_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control and output registers; reset discards every buffered entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= 8'h00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
        end
    end

    // Storage array; contents are only ever observed through the count-masked head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_entry_s;
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = head_q.data;
    assign bus.OUT_SEL   = head_q.sel;
    assign bus.OUT_ZERO  = head_q.zero;
    assign bus.OUT_NEG   = head_q.neg;
    assign bus.COUNT     = count_q;
    assign bus.DROP_CNT  = drop_q;

endmodule

// File: tb/tb_mux_result_buffer.sv
// Directed self-checking bench for mux_result_buffer (DEPTH=4, WIDTH=16).
module tb_mux_result_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mux_result_buffer_if bus ();

    mux_result_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.DATA_IN = 16'h0000; bus.SEL_IN = 2'd0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
        step();
        checks++;
        if ({bus.OUT_VALID, bus.IN_READY, bus.COUNT} !== {1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b ready=%b count=%0d, want 0 1 0", bus.OUT_VALID, bus.IN_READY, bus.COUNT);
        end
        checks++;
        if ({bus.OUT_DATA, bus.OUT_SEL, bus.OUT_ZERO, bus.OUT_NEG, bus.DROP_CNT} !== 28'h0) begin
            errors++;
            $display("FAIL reset_out: got data=%h sel=%0d z=%b n=%b drop=%0d, want all 0", bus.OUT_DATA, bus.OUT_SEL, bus.OUT_ZERO, bus.OUT_NEG, bus.DROP_CNT);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero_push();
        bus.DATA_IN = 16'h0000; bus.SEL_IN = 2'd2; bus.IN_VALID = 1'b1;
        step();
        bus.IN_VALID = 1'b0;
        checks++;
        if ({bus.OUT_VALID, bus.OUT_ZERO, bus.OUT_NEG, bus.OUT_SEL, bus.COUNT, bus.OUT_DATA} !== {1'b1, 1'b1, 1'b0, 2'd2, 3'd1, 16'h0000}) begin
            errors++;
            $display("FAIL zero_push: got valid=%b z=%b n=%b sel=%0d count=%0d data=%h, want 1 1 0 2 1 0000",
                     bus.OUT_VALID, bus.OUT_ZERO, bus.OUT_NEG, bus.OUT_SEL, bus.COUNT, bus.OUT_DATA);
        end
        // Pop it, then keep OUT_READY high while empty: nothing may underflow.
        bus.OUT_READY = 1'b1;
        step();
        step();
        bus.OUT_READY = 1'b0;
        checks++;
        if ({bus.OUT_VALID, bus.COUNT, bus.OUT_DATA, bus.OUT_SEL, bus.OUT_ZERO, bus.IN_READY} !== {1'b0, 3'd0, 16'h0000, 2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL empty_pop: got valid=%b count=%0d data=%h sel=%0d z=%b ready=%b, want 0 0 0000 0 0 1",
                     bus.OUT_VALID, bus.COUNT, bus.OUT_DATA, bus.OUT_SEL, bus.OUT_ZERO, bus.IN_READY);
        end
    endtask

    task automatic test_fill();
        logic [15:0] words [5];
        words[0] = 16'h8001; words[1] = 16'h0005; words[2] = 16'h7FFF; words[3] = 16'h1234; words[4] = 16'hAAAA;
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.DATA_IN = words[i]; bus.SEL_IN = 2'(i); bus.IN_VALID = 1'b1;
            step();
        end
        bus.IN_VALID = 1'b0;
        checks++;
        if ({bus.COUNT, bus.IN_READY, bus.DROP_CNT} !== {3'd4, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL fill_ctrl: got count=%0d ready=%b drop=%0d, want 4 0 1", bus.COUNT, bus.IN_READY, bus.DROP_CNT);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bus.OUT_VALID, bus.OUT_DATA, bus.OUT_SEL, bus.OUT_NEG, bus.OUT_ZERO} !== {1'b1, 16'h8001, 2'd0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL fill_head_hold%0d: got valid=%b data=%h sel=%0d n=%b z=%b, want 1 8001 0 1 0",
                         c, bus.OUT_VALID, bus.OUT_DATA, bus.OUT_SEL, bus.OUT_NEG, bus.OUT_ZERO);
            end
            step();
        end
    endtask

    task automatic test_full_pop();
        bus.DATA_IN = 16'hBEEF; bus.SEL_IN = 2'd3; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
        step();
        bus.OUT_READY = 1'b0;
        checks++;
        if ({bus.COUNT, bus.IN_READY, bus.DROP_CNT, bus.OUT_DATA} !== {3'd3, 1'b1, 8'd2, 16'h0005}) begin
            errors++;
            $display("FAIL full_pop_nobypass: got count=%0d ready=%b drop=%0d head=%h, want 3 1 2 0005",
                     bus.COUNT, bus.IN_READY, bus.DROP_CNT, bus.OUT_DATA);
        end
        step();
        bus.IN_VALID = 1'b0;
        checks++;
        if ({bus.COUNT, bus.IN_READY, bus.DROP_CNT} !== {3'd4, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL full_pop_refill: got count=%0d ready=%b drop=%0d, want 4 0 2", bus.COUNT, bus.IN_READY, bus.DROP_CNT);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        // Drain 0005 and 7FFF so the buffer holds 1234, BEEF.
        bus.OUT_READY = 1'b1;
        step();
        checks++;
        if (bus.OUT_DATA !== 16'h7FFF) begin
            errors++;
            $display("FAIL drain_head0: got %h, want 7fff", bus.OUT_DATA);
        end
        step();
        checks++;
        if ({bus.COUNT, bus.OUT_DATA, bus.OUT_SEL} !== {3'd2, 16'h1234, 2'd3}) begin
            errors++;
            $display("FAIL drain_head1: got count=%0d data=%h sel=%0d, want 2 1234 3", bus.COUNT, bus.OUT_DATA, bus.OUT_SEL);
        end
        for (int k = 0; k < 10; k++) begin
            bus.DATA_IN = 16'h0100 + 16'(k); bus.SEL_IN = 2'(k); bus.IN_VALID = 1'b1;
            step();
            exp = (k == 0) ? 16'hBEEF : (16'h0100 + 16'(k - 1));
            checks++;
            if ({bus.COUNT, bus.OUT_VALID, bus.OUT_DATA, bus.OUT_NEG} !== {3'd2, 1'b1, exp, exp[15]}) begin
                errors++;
                $display("FAIL b2b_%0d: got count=%0d valid=%b data=%h n=%b, want 2 1 %h %b",
                         k, bus.COUNT, bus.OUT_VALID, bus.OUT_DATA, bus.OUT_NEG, exp, exp[15]);
            end
        end
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.DATA_IN = 16'h00AA; bus.SEL_IN = 2'd1; bus.IN_VALID = 1'b1;
        step();
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.COUNT !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d, want 3", bus.COUNT);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.OUT_VALID, bus.COUNT, bus.DROP_CNT, bus.IN_READY, bus.OUT_DATA} !== {1'b0, 3'd0, 8'd0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL async_reset: got valid=%b count=%0d drop=%0d ready=%b data=%h, want 0 0 0 1 0000",
                     bus.OUT_VALID, bus.COUNT, bus.DROP_CNT, bus.IN_READY, bus.OUT_DATA);
        end
        step();
        rst_n = 1'b1;
        step();
        bus.DATA_IN = 16'h0042; bus.SEL_IN = 2'd1; bus.IN_VALID = 1'b1;
        step();
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
        checks++;
        if ({bus.COUNT, bus.OUT_VALID, bus.OUT_DATA, bus.OUT_SEL} !== {3'd1, 1'b1, 16'h0042, 2'd1}) begin
            errors++;
            $display("FAIL post_reset_first: got count=%0d valid=%b data=%h sel=%0d, want 1 1 0042 1",
                     bus.COUNT, bus.OUT_VALID, bus.OUT_DATA, bus.OUT_SEL);
        end
        step();
        bus.OUT_READY = 1'b0;
        checks++;
        if ({bus.COUNT, bus.OUT_VALID, bus.OUT_DATA} !== {3'd0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL post_reset_nostale: got count=%0d valid=%b data=%h, want 0 0 0000", bus.COUNT, bus.OUT_VALID, bus.OUT_DATA);
        end
    endtask

    task automatic test_drop_sat();
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.DATA_IN = 16'hD000 + 16'(i); bus.SEL_IN = 2'(i); bus.IN_VALID = 1'b1;
            step();
        end
        checks++;
        if ({bus.COUNT, bus.DROP_CNT} !== {3'd4, 8'd0}) begin
            errors++;
            $display("FAIL sat_prefill: got count=%0d drop=%0d, want 4 0", bus.COUNT, bus.DROP_CNT);
        end
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 99) begin
                checks++;
                if (bus.DROP_CNT !== 8'd100) begin
                    errors++;
                    $display("FAIL drop_100: got %0d, want 100", bus.DROP_CNT);
                end
            end
            if (i == 254) begin
                checks++;
                if (bus.DROP_CNT !== 8'hFF) begin
                    errors++;
                    $display("FAIL drop_255: got %h, want ff", bus.DROP_CNT);
                end
            end
        end
        bus.IN_VALID = 1'b0;
        checks++;
        if ({bus.DROP_CNT, bus.COUNT, bus.OUT_DATA} !== {8'hFF, 3'd4, 16'hD000}) begin
            errors++;
            $display("FAIL drop_saturate: got drop=%h count=%0d head=%h, want ff 4 d000", bus.DROP_CNT, bus.COUNT, bus.OUT_DATA);
        end
    endtask

    initial begin
        test_reset();
        test_zero_push();
        test_fill();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        test_drop_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
